dsp_chain_4_fp16_sop2_operand_feeder_8: RTL and testbench

Streaming operand packer on the producer side of the 8-lane fp16 SOP2 DSP-chain array. It accepts narrow fp16 operand beats over a valid/ready stream and assembles them into the 2048-bit operand bus. The bus carries 8 lanes × 256 bits, with 16 fp16 values per lane. Each completed frame is presented with a valid/ready handshake and held stable, because the array samples its input every cycle.

---
 rtl/dsp_chain_4_fp16_sop2_operand_feeder_8_pkg.sv | 22 ++
 rtl/dsp_chain_4_fp16_sop2_operand_feeder_8_if.sv | 26 ++
 rtl/dsp_chain_4_fp16_sop2_operand_feeder_8.sv | 69 ++++++
 tb/tb_dsp_chain_4_fp16_sop2_operand_feeder_8.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_chain_4_fp16_sop2_operand_feeder_8_pkg.sv
// Shared constants for the 8-lane fp16 SOP2 DSP-chain array: lane geometry,
// operand bus width and the fp16 +0.0 fill value.
package dsp_chain_4_fp16_sop2_operand_feeder_8_pkg;

  localparam int FP16_W    = 16;
  localparam int LANE_W    = 256;
  localparam int NUM_LANES = 8;
  localparam int BUS_W     = NUM_LANES * LANE_W;
  localparam int IN_W      = 256;
  localparam int BEATS     = BUS_W / IN_W;
  localparam int CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [FP16_W-1:0] FP16_POS_ZERO = 16'h0000;

  typedef logic [BUS_W-1:0] bus_t;
  typedef logic [IN_W-1:0]  beat_t;

  function automatic beat_t zero_beat();
    return {(IN_W/FP16_W){FP16_POS_ZERO}};
  endfunction

endpackage

// File: rtl/dsp_chain_4_fp16_sop2_operand_feeder_8_if.sv
// Producer-side stream into the feeder and frame stream out to the array.
interface dsp_chain_4_fp16_sop2_operand_feeder_8_if;
  import dsp_chain_4_fp16_sop2_operand_feeder_8_pkg::*;

  // Both streams: a transfer happens in any cycle where valid && ready at the
  // rising edge; data/last are don't-care when valid is low.
  logic             in_valid;
  logic             in_ready;
  beat_t            in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  bus_t             out_data;
  logic [CNT_W-1:0] beat_cnt;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, beat_cnt
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, beat_cnt
  );

endinterface

// File: rtl/dsp_chain_4_fp16_sop2_operand_feeder_8.sv
// Packs narrow fp16 operand beats into the 2048-bit operand bus and holds each
// completed frame stable for the array; short frames are zero-filled.
module dsp_chain_4_fp16_sop2_operand_feeder_8
  import dsp_chain_4_fp16_sop2_operand_feeder_8_pkg::*;
(
  input logic clk,
  input logic reset,
  dsp_chain_4_fp16_sop2_operand_feeder_8_if.slave bus
);

  logic [BUS_W-IN_W-1:0] fill_q;
  logic [CNT_W-1:0]      cnt_q;
  bus_t                  out_q;
  logic                  out_valid_q;

  logic completing;
  logic in_ready_w;
  logic accept;
  bus_t fill_ext;
  bus_t frame_d;

  assign completing = bus.in_last || (cnt_q == CNT_W'(BEATS-1));
  assign in_ready_w = !completing || !out_valid_q || bus.out_ready;
  assign accept     = bus.in_valid && in_ready_w;
  assign fill_ext   = {zero_beat(), fill_q};

  // Only slots below the current beat are taken from the fill buffer, so
  // leftovers from a longer earlier frame can never reach the bus.
  always_comb begin
    frame_d = {(BUS_W/FP16_W){FP16_POS_ZERO}};
    for (int k = 0; k < BEATS; k++) begin
      if (CNT_W'(k) == cnt_q)
        frame_d[k*IN_W +: IN_W] = bus.in_data;
      else if (CNT_W'(k) < cnt_q)
        frame_d[k*IN_W +: IN_W] = fill_ext[k*IN_W +: IN_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_q      <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (bus.out_ready)
        out_valid_q <= 1'b0;
      if (accept) begin
        if (completing) begin
          out_q       <= frame_d;
          out_valid_q <= 1'b1;
          cnt_q       <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
          for (int k = 0; k < BEATS-1; k++) begin
            if (cnt_q == CNT_W'(k))
              fill_q[k*IN_W +: IN_W] <= bus.in_data;
          end
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_q;
  assign bus.beat_cnt  = cnt_q;

endmodule

// File: tb/tb_dsp_chain_4_fp16_sop2_operand_feeder_8.sv
// Bench for the operand feeder: vector table, directed corner sequences and a
// randomized run against a frame-level queue model.
module tb_dsp_chain_4_fp16_sop2_operand_feeder_8;
  import dsp_chain_4_fp16_sop2_operand_feeder_8_pkg::*;

  typedef struct {
    logic [15:0]      val;
    logic             last;
    logic             ordy;
    logic [CNT_W-1:0] exp_cnt;
    logic             exp_ov;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dsp_chain_4_fp16_sop2_operand_feeder_8_if bus();

  dsp_chain_4_fp16_sop2_operand_feeder_8 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  bit rec_en = 1'b0;
  int cyc = 0;
  int ready_drops = 0;
  int pulse_q[$];
  vec_t vec[20];

  // ---------------- reference model ----------------
  beat_t m_cur[$];
  logic [BUS_W-1:0] exp_q[$];
  bus_t m_out = '0;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bus(input string name, input bus_t act, input bus_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      for (int w = 0; w < BUS_W/FP16_W; w++) begin
        if (act[w*FP16_W +: FP16_W] !== exp[w*FP16_W +: FP16_W]) begin
          $display("FAIL %s: fp16 word %0d got %h expected %h at %0t",
                   name, w, act[w*FP16_W +: FP16_W], exp[w*FP16_W +: FP16_W], $time);
          break;
        end
      end
    end
  endtask

  function automatic beat_t rep16(input logic [15:0] v);
    return {(IN_W/FP16_W){v}};
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    for (int i = 0; i < IN_W/32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic void set_vec(input int i, input logic [15:0] v, input logic l,
                                  input logic o, input int c, input logic ov);
    vec[i].val = v;
    vec[i].last = l;
    vec[i].ordy = o;
    vec[i].exp_cnt = CNT_W'(c);
    vec[i].exp_ov = ov;
  endfunction

  // Scoreboard: every frame that completes is offered exactly once; out_data
  // always shows the most recently completed frame.
  always @(negedge clk) begin : monitor
    logic exp_ready;
    bus_t f;
    if (chk_en) begin
      cyc++;
      exp_ready = !((m_cur.size() == BEATS-1) || bus.in_last) || (exp_q.size() == 0) || bus.out_ready;
      if (bus.in_valid) check_val("in_ready", 32'(bus.in_ready), 32'(exp_ready));
      check_val("out_valid", 32'(bus.out_valid), (exp_q.size() != 0) ? 32'd1 : 32'd0);
      check_val("beat_cnt", 32'(bus.beat_cnt), 32'(m_cur.size()));
      check_bus("out_data", bus.out_data, m_out);
      if (rec_en) begin
        if (bus.out_valid) pulse_q.push_back(cyc);
        if (!bus.in_ready) ready_drops++;
      end
      if (reset) begin
        m_cur.delete();
        exp_q.delete();
        m_out = '0;
      end else begin
        if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
        if (bus.in_valid && exp_ready) begin
          m_cur.push_back(bus.in_data);
          if (bus.in_last || m_cur.size() == BEATS) begin
            f = '0;
            foreach (m_cur[k]) f[k*IN_W +: IN_W] = m_cur[k];
            exp_q.push_back(f);
            m_out = f;
            m_cur.delete();
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send_beat(input beat_t d, input logic l);
    int n;
    logic ok;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_last = l;
    n = 0;
    do begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) check_val("send_beat_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    bus_t f_ord, f_short, f_stale, f_a, f_b, f_c;

    for (int k = 0; k < 8; k++) set_vec(k, 16'h3C00 + 16'(k), 1'b0, 1'b1, (k + 1) % BEATS, k == 7);
    for (int k = 0; k < 3; k++) set_vec(8 + k, 16'h4000, k == 2, 1'b1, (k == 2) ? 0 : k + 1, k == 2);
    for (int k = 0; k < 8; k++) set_vec(11 + k, 16'hFFFF, k == 7, 1'b1, (k + 1) % BEATS, k == 7);
    set_vec(19, 16'h1234, 1'b1, 1'b1, 0, 1'b1);

    f_ord = '0; f_short = '0; f_stale = '0; f_a = '0; f_b = '0; f_c = '0;
    for (int k = 0; k < 8; k++) begin
      f_ord[k*IN_W +: IN_W] = rep16(16'h3C00 + 16'(k));
      f_a[k*IN_W +: IN_W]   = rep16(16'hA000 + 16'(k));
      f_b[k*IN_W +: IN_W]   = rep16(16'hB000 + 16'(k));
      f_c[k*IN_W +: IN_W]   = rep16(16'hC000 + 16'(k));
    end
    for (int k = 0; k < 3; k++) f_short[k*IN_W +: IN_W] = rep16(16'h4000);
    f_stale[IN_W-1:0] = rep16(16'h1234);

    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;

    @(negedge clk);
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_val("rst_beat_cnt", 32'(bus.beat_cnt), 32'd0);
    check_bus("rst_out_data", bus.out_data, '0);
    @(posedge clk);
    #1;

    // ordered fill, short frame, stale-data frames
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = rep16(vec[i].val);
      bus.in_last = vec[i].last;
      bus.out_ready = vec[i].ordy;
      @(posedge clk);
      #1;
      check_val($sformatf("vec%0d_beat_cnt", i), 32'(bus.beat_cnt), 32'(vec[i].exp_cnt));
      check_val($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vec[i].exp_ov));
      if (i == 7)  check_bus("ordered_frame", bus.out_data, f_ord);
      if (i == 10) check_bus("short_frame", bus.out_data, f_short);
      if (i == 19) check_bus("stale_frame", bus.out_data, f_stale);
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // back-pressure
    bus.out_ready = 1'b0;
    for (int k = 0; k < 8; k++) send_beat(rep16(16'hA000 + 16'(k)), 1'b0);
    for (int k = 0; k < 7; k++) send_beat(rep16(16'hB000 + 16'(k)), 1'b0);
    bus.in_data = rep16(16'hB007);
    bus.in_last = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_val("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check_val("bp_beat_cnt", 32'(bus.beat_cnt), 32'd7);
      check_bus("bp_hold", bus.out_data, f_a);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check_val("bp_swap_valid", 32'(bus.out_valid), 32'd1);
    check_val("bp_swap_cnt", 32'(bus.beat_cnt), 32'd0);
    check_bus("bp_swap_data", bus.out_data, f_b);
    @(posedge clk);
    #1;

    // streaming
    bus.out_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    pulse_q.delete();
    ready_drops = 0;
    rec_en = 1'b1;
    for (int fr = 0; fr < 4; fr++)
      for (int k = 0; k < 8; k++) send_beat(rep16(16'h5000 + 16'(fr*16 + k)), 1'b0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rec_en = 1'b0;
    check_val("stream_pulses", 32'(pulse_q.size()), 32'd4);
    for (int i = 1; i < pulse_q.size(); i++)
      check_val("stream_spacing", 32'(pulse_q[i] - pulse_q[i-1]), 32'd8);
    check_val("stream_ready_drops", 32'(ready_drops), 32'd0);

    // reset mid-frame with a pending frame
    bus.out_ready = 1'b0;
    for (int k = 0; k < 8; k++) send_beat(rep16(16'h7000 + 16'(k)), 1'b0);
    for (int k = 0; k < 5; k++) send_beat(rep16(16'h7100 + 16'(k)), 1'b0);
    check_val("pre_rst_cnt", 32'(bus.beat_cnt), 32'd5);
    check_val("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check_val("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    check_val("mid_rst_cnt", 32'(bus.beat_cnt), 32'd0);
    check_bus("mid_rst_data", bus.out_data, '0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) send_beat(rep16(16'hC000 + 16'(k)), 1'b0);
    bus.in_valid = 1'b0;
    check_val("clean_valid", 32'(bus.out_valid), 32'd1);
    check_bus("clean_frame", bus.out_data, f_c);
    @(posedge clk);
    #1;

    // randomized traffic, with one reset in the middle
    for (int c = 0; c < 1000; c++) begin
      bus.in_valid = ($urandom_range(0, 9) < 7);
      bus.in_data = rand_beat();
      bus.in_last = ($urandom_range(0, 9) == 0);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      reset = (c == 500);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
